ram_port_arbiter: RTL and testbench

//  Shares the single-port data RAM (one write or one read per cycle, read data valid the cycle after
//  the address is sampled) between two requesters: M0 = core load/store unit, M1 = debug/loader port.

---
 rtl/ram_port_arbiter_pkg.sv | 16 +
 rtl/ram_arb_rr.sv | 27 ++
 rtl/ram_port_arbiter.sv | 144 ++++++++++++++
 tb/tb_ram_port_arbiter.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/ram_port_arbiter_pkg.sv
// Shared constants for the two-master RAM port arbiter.
package ram_port_arbiter_pkg;

  // Requester ids: M0 = core load/store unit, M1 = debug/loader port.
  typedef enum logic {
    MId0 = 1'b0,
    MId1 = 1'b1
  } master_id_e;

  localparam int unsigned LockMaxDefault = 8;

  function automatic master_id_e other_master(master_id_e id);
    return master_id_e'(~id);
  endfunction

endpackage

// File: rtl/ram_arb_rr.sv
// Two-way round-robin picker with a lock override for the current owner.
module ram_arb_rr
  import ram_port_arbiter_pkg::*;
(
  input  logic [1:0] req_i,
  input  master_id_e ptr_i,
  input  logic       lock_vld_i,
  input  master_id_e lock_id_i,
  output logic [1:0] gnt_o
);

  // Locked owner first, then a lone requester, then the pointer breaks the tie.
  always_comb begin
    gnt_o = 2'b00;
    if (lock_vld_i && req_i[lock_id_i]) begin
      gnt_o[lock_id_i] = 1'b1;
    end else begin
      unique case (req_i)
        2'b01:   gnt_o = 2'b01;
        2'b10:   gnt_o = 2'b10;
        2'b11:   gnt_o[ptr_i] = 1'b1;
        default: gnt_o = 2'b00;
      endcase
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares a single-port data RAM between the core LSU (M0) and the debug/loader port (M1).
module ram_port_arbiter
  import ram_port_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DEPTH_WORDS = 32,
  parameter int unsigned LOCK_MAX    = LockMaxDefault
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req_i,
  input  logic              m0_we_i,
  input  logic              m0_lock_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [DATA_W-1:0] m0_wdata_i,
  output logic              m0_gnt_o,
  output logic              m0_rvalid_o,
  output logic [DATA_W-1:0] m0_rdata_o,
  output logic              m0_err_o,
  input  logic              m1_req_i,
  input  logic              m1_we_i,
  input  logic              m1_lock_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [DATA_W-1:0] m1_wdata_i,
  output logic              m1_gnt_o,
  output logic              m1_rvalid_o,
  output logic [DATA_W-1:0] m1_rdata_o,
  output logic              m1_err_o,
  output logic              ram_wr_en_o,
  output logic [ADDR_W-1:0] ram_wr_addr_o,
  output logic [DATA_W-1:0] ram_wr_data_o,
  output logic [ADDR_W-1:0] ram_rd_addr_o,
  input  logic [DATA_W-1:0] ram_rd_data_i
);

  localparam int unsigned CntW = $clog2(LOCK_MAX + 1);
  localparam logic [CntW-1:0]     LockMaxC = CntW'(LOCK_MAX);
  localparam logic [ADDR_W-3:0]   DepthIdx = (ADDR_W - 2)'(DEPTH_WORDS);

  master_id_e        ptr_q, ptr_d;
  master_id_e        owner_q, owner_d;
  logic              owner_vld_q, owner_vld_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [1:0]        rvalid_q, rvalid_d;
  logic              rd_oor_q, rd_oor_d;
  logic [1:0]        err_q, err_d;

  logic [1:0]        req, lock, rr_gnt, gnt;
  logic              gnt_any, rd_fire;
  master_id_e        gnt_id;
  logic              win_we, win_lock, win_oor;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;

  assign req  = {m1_req_i, m0_req_i};
  assign lock = {m1_lock_i, m0_lock_i};

  ram_arb_rr u_rr (
    .req_i      (req),
    .ptr_i      (ptr_q),
    .lock_vld_i (owner_vld_q && lock[owner_q]),
    .lock_id_i  (owner_q),
    .gnt_o      (rr_gnt)
  );

  // Winner selection and RAM port muxing; nothing is granted while in reset.
  always_comb begin
    gnt       = rst_n ? rr_gnt : 2'b00;
    gnt_any   = |gnt;
    gnt_id    = master_id_e'(gnt[1]);
    win_we    = gnt_id == MId1 ? m1_we_i    : m0_we_i;
    win_lock  = gnt_id == MId1 ? m1_lock_i  : m0_lock_i;
    win_addr  = gnt_id == MId1 ? m1_addr_i  : m0_addr_i;
    win_wdata = gnt_id == MId1 ? m1_wdata_i : m0_wdata_i;
    win_oor   = win_addr[ADDR_W-1:2] >= DepthIdx;
    rd_fire   = gnt_any && !win_we;
  end

  assign m0_gnt_o      = gnt[0];
  assign m1_gnt_o      = gnt[1];
  assign ram_wr_en_o   = gnt_any && win_we && !win_oor;
  assign ram_wr_addr_o = win_addr;
  assign ram_wr_data_o = win_wdata;
  assign ram_rd_addr_o = rd_fire ? win_addr : rd_addr_q;

  // Ownership, lock counting and pointer rotation.
  always_comb begin
    cnt_d       = '0;
    owner_d     = owner_q;
    owner_vld_d = 1'b0;
    ptr_d       = ptr_q;
    rd_addr_d   = rd_fire ? win_addr : rd_addr_q;
    rvalid_d    = rd_fire ? gnt : 2'b00;
    rd_oor_d    = rd_fire && win_oor;
    err_d       = (gnt_any && win_oor) ? gnt : 2'b00;
    if (gnt_any) begin
      // A run at LOCK_MAX restarts at 1 when the owner continues uncontested.
      if (cnt_q != '0 && owner_q == gnt_id && cnt_q != LockMaxC) begin
        cnt_d = cnt_q + CntW'(1);
      end else begin
        cnt_d = CntW'(1);
      end
      owner_d     = gnt_id;
      owner_vld_d = win_lock && (cnt_d != LockMaxC);
      if (!owner_vld_d) begin
        ptr_d = other_master(gnt_id);
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q       <= MId0;
      owner_q     <= MId0;
      owner_vld_q <= 1'b0;
      cnt_q       <= '0;
      rd_addr_q   <= '0;
      rvalid_q    <= 2'b00;
      rd_oor_q    <= 1'b0;
      err_q       <= 2'b00;
    end else begin
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      owner_vld_q <= owner_vld_d;
      cnt_q       <= cnt_d;
      rd_addr_q   <= rd_addr_d;
      rvalid_q    <= rvalid_d;
      rd_oor_q    <= rd_oor_d;
      err_q       <= err_d;
    end
  end

  // Gated by rst_n so a read in flight when reset asserts is never reported.
  assign m0_rvalid_o = rvalid_q[0] && rst_n;
  assign m1_rvalid_o = rvalid_q[1] && rst_n;
  assign m0_err_o    = err_q[0] && rst_n;
  assign m1_err_o    = err_q[1] && rst_n;
  assign m0_rdata_o  = (rvalid_q[0] && !rd_oor_q) ? ram_rd_data_i : '0;
  assign m1_rdata_o  = (rvalid_q[1] && !rd_oor_q) ? ram_rd_data_i : '0;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a behavioural write-first RAM.
module tb_ram_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0_req, m0_we, m0_lock, m1_req, m1_we, m1_lock;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic        ram_wr_en;
  logic [31:0] ram_wr_addr, ram_wr_data, ram_rd_addr, ram_rd_data;

  logic [31:0] mem [32];
  int          n_pass = 0;
  int          n_total = 0;

  always #5 clk = ~clk;

  ram_port_arbiter dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .m0_req_i      (m0_req),
    .m0_we_i       (m0_we),
    .m0_lock_i     (m0_lock),
    .m0_addr_i     (m0_addr),
    .m0_wdata_i    (m0_wdata),
    .m0_gnt_o      (m0_gnt),
    .m0_rvalid_o   (m0_rvalid),
    .m0_rdata_o    (m0_rdata),
    .m0_err_o      (m0_err),
    .m1_req_i      (m1_req),
    .m1_we_i       (m1_we),
    .m1_lock_i     (m1_lock),
    .m1_addr_i     (m1_addr),
    .m1_wdata_i    (m1_wdata),
    .m1_gnt_o      (m1_gnt),
    .m1_rvalid_o   (m1_rvalid),
    .m1_rdata_o    (m1_rdata),
    .m1_err_o      (m1_err),
    .ram_wr_en_o   (ram_wr_en),
    .ram_wr_addr_o (ram_wr_addr),
    .ram_wr_data_o (ram_wr_data),
    .ram_rd_addr_o (ram_rd_addr),
    .ram_rd_data_i (ram_rd_data)
  );

  // RAM model: 32 words preset to A000_00nn on reset, write-first, junk when out of range.
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) mem[i] <= 32'hA000_0000 + 32'(i);
      ram_rd_data <= 32'h0;
    end else begin
      if (ram_wr_en) mem[ram_wr_addr[6:2]] <= ram_wr_data;
      if (ram_wr_en && ram_wr_addr[31:2] == ram_rd_addr[31:2]) ram_rd_data <= ram_wr_data;
      else if (ram_rd_addr[31:2] < 30'd32) ram_rd_data <= mem[ram_rd_addr[6:2]];
      else ram_rd_data <= 32'hBAD0_BAD0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic idle();
    m0_req = 0; m0_we = 0; m0_lock = 0;
    m1_req = 0; m1_we = 0; m1_lock = 0;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    idle();
    m0_addr = 32'h4; m1_addr = 32'h8; m0_wdata = 32'h1111_1111; m1_wdata = 32'h2222_2222;
    // Reset held with both masters requesting, M0 trying to write.
    rst_n = 0; m0_req = 1; m0_we = 1; m1_req = 1;
    for (int i = 0; i < 2; i++) begin
      step(); #1;
      check("rst_gnt0", m0_gnt, 0);
      check("rst_gnt1", m1_gnt, 0);
      check("rst_wr_en", ram_wr_en, 0);
      check("rst_rvalid", {m1_rvalid, m0_rvalid}, 0);
    end
    // Release: M0 wins first; both keep reading and grants alternate.
    step(); rst_n = 1; m0_we = 0; #1;
    check("rel_gnt0", m0_gnt, 1);
    check("rel_gnt1", m1_gnt, 0);
    check("rel_rd_addr", ram_rd_addr, 32'h4);
    step(); #1;
    check("alt1_gnt1", m1_gnt, 1);
    check("alt1_rvalid0", m0_rvalid, 1);
    check("alt1_rdata0", m0_rdata, 32'hA000_0001);
    check("alt1_rd_addr", ram_rd_addr, 32'h8);
    step(); #1;
    check("alt2_gnt0", m0_gnt, 1);
    check("alt2_rvalid1", m1_rvalid, 1);
    check("alt2_rvalid0", m0_rvalid, 0);
    check("alt2_rdata1", m1_rdata, 32'hA000_0002);
    step(); #1;
    check("alt3_gnt1", m1_gnt, 1);
    check("alt3_rdata0", m0_rdata, 32'hA000_0001);
    step(); idle(); #1;
    check("idle_gnt", {m1_gnt, m0_gnt}, 0);
    check("idle_rvalid1", m1_rvalid, 1);
    check("idle_rd_addr_hold", ram_rd_addr, 32'h8);
    step(); #1;
    check("idle2_rvalid", {m1_rvalid, m0_rvalid}, 0);

    // Write from M0 then read of the same word by M1.
    step(); m0_req = 1; m0_we = 1; m0_addr = 32'h10; m0_wdata = 32'hDEAD_BEEF; #1;
    check("wr_gnt0", m0_gnt, 1);
    check("wr_en", ram_wr_en, 1);
    check("wr_addr", ram_wr_addr, 32'h10);
    check("wr_data", ram_wr_data, 32'hDEAD_BEEF);
    step(); idle(); m1_req = 1; m1_addr = 32'h10; #1;
    check("rd_gnt1", m1_gnt, 1);
    check("rd_wr_en", ram_wr_en, 0);
    check("rd_addr", ram_rd_addr, 32'h10);
    step(); idle(); #1;
    check("raw_rvalid1", m1_rvalid, 1);
    check("raw_rdata1", m1_rdata, 32'hDEAD_BEEF);

    // Locked burst from M1: eight grants in a row, then M0 gets through.
    step(); m1_req = 1; m1_lock = 1; m1_addr = 32'h8; #1;
    check("lock_first_gnt1", m1_gnt, 1);
    step(); m0_req = 1; m0_addr = 32'h4; #1;
    check("lock_k1_gnt1", m1_gnt, 1);
    check("lock_k1_gnt0", m0_gnt, 0);
    for (int i = 2; i <= 7; i++) begin
      step(); #1;
      check($sformatf("lock_k%0d_gnt", i), {m1_gnt, m0_gnt}, 2'b10);
    end
    step(); #1;
    check("lock_release_gnt", {m1_gnt, m0_gnt}, 2'b01);
    check("lock_release_rdata1", m1_rdata, 32'hA000_0002);
    step(); #1;
    check("post_lock_gnt", {m1_gnt, m0_gnt}, 2'b10);
    check("post_lock_rdata0", m0_rdata, 32'hA000_0001);
    step(); idle(); #1;
    check("post_lock_rvalid1", m1_rvalid, 1);

    // Out-of-range write and read at word 32, then in-range boundary word 31.
    step(); m0_req = 1; m0_we = 1; m0_addr = 32'h80; m0_wdata = 32'h55; #1;
    check("oor_wr_gnt0", m0_gnt, 1);
    check("oor_wr_en", ram_wr_en, 0);
    check("oor_err_before", m0_err, 0);
    step(); m0_we = 0; #1;
    check("oor_rd_gnt0", m0_gnt, 1);
    check("oor_wr_err", m0_err, 1);
    check("oor_rd_rvalid_early", m0_rvalid, 0);
    step(); idle(); #1;
    check("oor_rd_rvalid", m0_rvalid, 1);
    check("oor_rd_rdata", m0_rdata, 32'h0);
    check("oor_rd_err", m0_err, 1);
    step(); m1_req = 1; m1_we = 1; m1_addr = 32'h7C; m1_wdata = 32'h1234_5678; #1;
    check("top_wr_en", ram_wr_en, 1);
    check("top_wr_addr", ram_wr_addr, 32'h7C);
    check("oor_err_clear", m0_err, 0);
    step(); idle(); #1;
    check("top_wr_err", m1_err, 0);

    // Reset with an M0 read in flight; pointer would otherwise favour M1.
    step(); m0_req = 1; m0_addr = 32'h4; #1;
    check("inflight_gnt0", m0_gnt, 1);
    step(); rst_n = 0; m1_req = 1; m1_addr = 32'h8; #1;
    check("inflight_rvalid0", m0_rvalid, 0);
    check("inflight_gnt", {m1_gnt, m0_gnt}, 0);
    step(); rst_n = 1; #1;
    check("rerel_gnt", {m1_gnt, m0_gnt}, 2'b01);
    check("rerel_rvalid", {m1_rvalid, m0_rvalid}, 0);
    step(); #1;
    check("rerel_rvalid0", m0_rvalid, 1);
    check("rerel_rdata0", m0_rdata, 32'hA000_0001);
    check("rerel_gnt1", m1_gnt, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
